// File: rtl/async_frame_pkg.sv
// async_frame_pkg: frame constants and receiver state encoding shared with the transmitter
package async_frame_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DEF_WIDTH  = 8;
  localparam int   FRAME_BITS = DEF_WIDTH + 2;
  function automatic int frame_bits(input int width);
    return width + 2;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  // shift the async input through two flops before anyone looks at it
  always_ff @(posedge clk_i)
    if (rst_i) {q_o, meta_q} <= {2{RST_VAL}};
    else {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/async_receiver.sv
// async_receiver: start/WIDTH data (MSB first)/stop serial receiver with mid-bit sampling
module async_receiver
  import async_frame_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RXD,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             RX_BUSY,
  output logic             FRAME_ERR
);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  localparam int CW  = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW  = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID > 0 ? MID - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
  logic             valid_q, valid_d, err_q, err_d, busy_q;
  logic             rxd_s, rxd_prev_q, start_det;
  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (RXD),
    .q_o  (rxd_s)
  );
  // rxd_prev resets low so a line already low at reset release is not taken as a start
  assign start_det = rxd_prev_q == STOP_BIT && rxd_s == START_BIT;
  // next-state: count down to each bit midpoint, then act on the sampled line
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (start_det) begin
        state_d   = MID == 0 ? DATA : START;
        cnt_d     = MID == 0 ? CNT_BIT : CNT_MID;
        bit_cnt_d = '0;
      end
      START: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        state_d   = rxd_s == START_BIT ? DATA : IDLE;
        cnt_d     = CNT_BIT;
        bit_cnt_d = '0;
      end
      DATA: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        shreg_d   = {shreg_q[WIDTH-2:0], rxd_s};
        cnt_d     = CNT_BIT;
        state_d   = bit_cnt_q == LAST_BIT ? STOP : DATA;
        bit_cnt_d = bit_cnt_q == LAST_BIT ? bit_cnt_q : bit_cnt_q + 1'b1;
      end
      STOP: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        state_d = IDLE;
        valid_d = rxd_s == STOP_BIT;
        err_d   = rxd_s != STOP_BIT;
        data_d  = rxd_s == STOP_BIT ? shreg_q : data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any frame in flight
  always_ff @(posedge CLK)
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rxd_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= state_d != IDLE;
      rxd_prev_q <= rxd_s;
    end
  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = err_q;
  assign RX_BUSY   = busy_q;
endmodule
